// File: rtl/sort_pkg.sv
// Shared types and helpers for the streaming odd-even transposition sorter.
package sort_pkg;

  typedef enum logic [1:0] {
    LOAD,
    SORT,
    UNLOAD
  } state_e;

  // One spare bit above the index width, so a count of NUM_ELEM is representable.
  localparam int unsigned CNT_HEADROOM = 1;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n) + CNT_HEADROOM;
  endfunction

  // Role of position idx in a pass of the given parity: bit0 = lower of a pair, bit1 = upper.
  function automatic logic [1:0] pair_role(input logic odd, input int unsigned idx,
                                           input int unsigned n);
    logic [1:0]  role;
    int unsigned below;
    below   = idx - 1;
    role    = 2'b00;
    role[0] = ((idx + 1) < n) && (idx[0] == odd);
    role[1] = (idx >= 1) && (below[0] == odd);
    return role;
  endfunction

endpackage

// File: rtl/cmp_swap_cell.sv
// Combinational compare-exchange of two words; equal words are never swapped.
module cmp_swap_cell #(
  parameter int unsigned SIZE_DATA = 8,
  parameter bit          DESCEND   = 1'b0
) (
  input  logic [SIZE_DATA-1:0] a,
  input  logic [SIZE_DATA-1:0] b,
  output logic [SIZE_DATA-1:0] lo_c,
  output logic [SIZE_DATA-1:0] hi_c
);

  logic swap;

  always_comb begin
    swap = DESCEND ? (a < b) : (b < a);
    lo_c = swap ? b : a;
    hi_c = swap ? a : b;
  end

endmodule

// File: rtl/stream_sort_engine.sv
// Frame sorter: load NUM_ELEM words, run NUM_ELEM odd-even transposition passes, stream them out.
module stream_sort_engine
  import sort_pkg::*;
#(
  parameter int unsigned SIZE_DATA = 8,
  parameter int unsigned NUM_ELEM  = 8,
  parameter bit          DESCEND   = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [SIZE_DATA-1:0] i_in_data,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [SIZE_DATA-1:0] o_out_data,
  output logic                 o_out_last,
  output logic                 o_busy
);

  localparam int unsigned CNT_W    = cnt_width(NUM_ELEM);
  localparam int unsigned IDX_W    = $clog2(NUM_ELEM);
  localparam int unsigned NUM_PAIR = NUM_ELEM / 2;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ELEM - 1);

  state_e               state;
  logic [CNT_W-1:0]     in_cnt;
  logic [CNT_W-1:0]     pass_cnt;
  logic [CNT_W-1:0]     out_cnt;
  logic [CNT_W-1:0]     out_nxt;
  logic [SIZE_DATA-1:0] mem      [NUM_ELEM];
  logic [SIZE_DATA-1:0] even_res [NUM_ELEM];
  logic [SIZE_DATA-1:0] odd_res  [NUM_ELEM];
  logic [SIZE_DATA-1:0] pass_res [NUM_ELEM];
  logic                 in_fire;
  logic                 out_fire;

  // Even-pass cells: (0,1), (2,3), ...
  for (genvar p = 0; p < NUM_PAIR; p++) begin : g_even
    cmp_swap_cell #(.SIZE_DATA(SIZE_DATA), .DESCEND(DESCEND)) u_cell (
      .a    (mem[2*p]),
      .b    (mem[2*p+1]),
      .lo_c (even_res[2*p]),
      .hi_c (even_res[2*p+1])
    );
  end

  // Odd-pass cells: (1,2), (3,4), ...; the two endpoints pass through.
  for (genvar p = 0; p < NUM_PAIR - 1; p++) begin : g_odd
    cmp_swap_cell #(.SIZE_DATA(SIZE_DATA), .DESCEND(DESCEND)) u_cell (
      .a    (mem[2*p+1]),
      .b    (mem[2*p+2]),
      .lo_c (odd_res[2*p+1]),
      .hi_c (odd_res[2*p+2])
    );
  end

  assign odd_res[0]          = mem[0];
  assign odd_res[NUM_ELEM-1] = mem[NUM_ELEM-1];

  // Per-pass writeback mux; positions outside the active pair pattern keep their word.
  always_comb begin
    for (int unsigned i = 0; i < NUM_ELEM; i++) begin
      pass_res[i] = mem[i];
      if (|pair_role(pass_cnt[0], i, NUM_ELEM)) begin
        pass_res[i] = pass_cnt[0] ? odd_res[i] : even_res[i];
      end
    end
  end

  assign in_fire  = o_in_ready & i_in_valid;
  assign out_fire = o_out_valid & i_out_ready;
  assign out_nxt  = out_cnt + CNT_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= LOAD;
      in_cnt      <= '0;
      pass_cnt    <= '0;
      out_cnt     <= '0;
      o_in_ready  <= 1'b1;
      o_out_valid <= 1'b0;
      o_out_last  <= 1'b0;
      o_busy      <= 1'b0;
      o_out_data  <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_fire) begin
            mem[in_cnt[IDX_W-1:0]] <= i_in_data;
            if (in_cnt == LAST_IDX) begin
              in_cnt     <= '0;
              state      <= SORT;
              o_in_ready <= 1'b0;
              o_busy     <= 1'b1;
            end else begin
              in_cnt <= in_cnt + CNT_W'(1);
            end
          end
        end
        SORT: begin
          for (int unsigned i = 0; i < NUM_ELEM; i++) begin
            mem[i] <= pass_res[i];
          end
          if (pass_cnt == LAST_IDX) begin
            // First output word comes straight from the final pass result.
            pass_cnt    <= '0;
            state       <= UNLOAD;
            o_out_valid <= 1'b1;
            o_out_data  <= pass_res[0];
            o_out_last  <= 1'b0;
          end else begin
            pass_cnt <= pass_cnt + CNT_W'(1);
          end
        end
        UNLOAD: begin
          if (out_fire) begin
            if (out_cnt == LAST_IDX) begin
              out_cnt     <= '0;
              state       <= LOAD;
              o_out_valid <= 1'b0;
              o_out_last  <= 1'b0;
              o_busy      <= 1'b0;
              o_in_ready  <= 1'b1;
            end else begin
              out_cnt    <= out_nxt;
              o_out_data <= mem[out_nxt[IDX_W-1:0]];
              o_out_last <= (out_nxt == LAST_IDX);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_sort_engine.sv
// Bench for stream_sort_engine: ascending and descending instances share one input stream.
module tb_stream_sort_engine;

  localparam int unsigned W = 8;
  localparam int unsigned N = 8;

  typedef logic [W-1:0] frame_t [N];

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b1;

  logic         in_ready_a, out_valid_a, out_last_a, busy_a;
  logic         in_ready_d, out_valid_d, out_last_d, busy_d;
  logic [W-1:0] out_data_a, out_data_d;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  // Results recorded by the drive/collect tasks for the most recent frame.
  int     hs_cyc, n_got, last_a, last_d, hold_err, proto_err, first_valid;
  bit     timeout, idle_after, busy_in_load;
  frame_t got_a, got_d;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stream_sort_engine #(.SIZE_DATA(W), .NUM_ELEM(N), .DESCEND(1'b0)) dut_asc (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready_a),
    .i_in_data(in_data), .o_out_valid(out_valid_a), .i_out_ready(out_ready),
    .o_out_data(out_data_a), .o_out_last(out_last_a), .o_busy(busy_a)
  );

  stream_sort_engine #(.SIZE_DATA(W), .NUM_ELEM(N), .DESCEND(1'b1)) dut_desc (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready_d),
    .i_in_data(in_data), .o_out_valid(out_valid_d), .i_out_ready(out_ready),
    .o_out_data(out_data_d), .o_out_last(out_last_d), .o_busy(busy_d)
  );

  // Reference: plain selection sort of the frame.
  task automatic model_sort(input frame_t d, input bit desc, output frame_t r);
    logic [W-1:0] t;
    r = d;
    for (int i = 0; i < N; i++) begin
      for (int j = i + 1; j < N; j++) begin
        if (desc ? (r[j] > r[i]) : (r[j] < r[i])) begin
          t = r[i]; r[i] = r[j]; r[j] = t;
        end
      end
    end
  endtask

  task automatic load_frame(input frame_t d, input bit gaps);
    int i = 0;
    int budget = 0;
    bit tog = 1'b0;
    busy_in_load = 1'b0;
    timeout = 1'b0;
    while (i < N && budget < 200) begin
      @(negedge clk);
      budget++;
      if (busy_a || busy_d) busy_in_load = 1'b1;
      tog = gaps ? ~tog : 1'b1;
      in_valid = tog;
      in_data = d[i];
      if (tog && in_ready_a) begin
        hs_cyc = cyc;
        i++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (i < N) timeout = 1'b1;
  endtask

  // mode 0: always ready, 1: ready toggles each cycle, 2: random ready.
  task automatic unload_frame(input int mode);
    int budget = 0;
    bit rdy = 1'b0;
    bit prev_stall = 1'b0;
    logic [W-1:0] pd = '0;
    logic pl = 1'b0;
    n_got = 0; last_a = 0; last_d = 0; hold_err = 0; proto_err = 0; first_valid = -1;
    while (n_got < N && budget < 400) begin
      @(negedge clk);
      budget++;
      in_valid = 1'($urandom_range(0, 1));
      in_data = W'($urandom);
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ~rdy;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      if (in_ready_a || in_ready_d || !busy_a || !busy_d || (out_valid_a !== out_valid_d))
        proto_err++;
      if (out_valid_a) begin
        if (first_valid < 0) first_valid = cyc;
        if (prev_stall && ((out_data_a !== pd) || (out_last_a !== pl))) hold_err++;
        pd = out_data_a;
        pl = out_last_a;
        prev_stall = !rdy;
        if (rdy) begin
          got_a[n_got] = out_data_a;
          got_d[n_got] = out_data_d;
          if (out_last_a) last_a |= (1 << n_got);
          if (out_last_d) last_d |= (1 << n_got);
          n_got++;
        end
      end
    end
    if (n_got < N) timeout = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle_after = !out_valid_a && !out_valid_d && in_ready_a && !busy_a;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready_a); end
    n_checks++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid_a); end
    n_checks++; if (out_last_a !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b expected 0", out_last_a); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    n_checks++; if (out_data_a !== 8'd0) begin n_fail++; $display("FAIL reset_out_data: got %0d expected 0", out_data_a); end
    n_checks++; if (in_ready_d !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_desc: got %b expected 1", in_ready_d); end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_reverse();
    frame_t d = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    frame_t ea, ed;
    model_sort(d, 1'b0, ea); model_sort(d, 1'b1, ed);
    load_frame(d, 1'b0); unload_frame(0);
    n_checks++; if (timeout) begin n_fail++; $display("FAIL reverse_timeout: got %0d words expected %0d", n_got, N); end
    for (int i = 0; i < N; i++) begin
      n_checks++; if (got_a[i] !== ea[i]) begin n_fail++; $display("FAIL reverse_asc[%0d]: got %0d expected %0d", i, got_a[i], ea[i]); end
      n_checks++; if (got_d[i] !== ed[i]) begin n_fail++; $display("FAIL reverse_desc[%0d]: got %0d expected %0d", i, got_d[i], ed[i]); end
    end
    n_checks++; if (last_a !== 128) begin n_fail++; $display("FAIL reverse_last: got mask %0d expected 128", last_a); end
    n_checks++; if (first_valid - hs_cyc !== 9) begin n_fail++; $display("FAIL reverse_latency: got %0d expected 9", first_valid - hs_cyc); end
    n_checks++; if (proto_err !== 0) begin n_fail++; $display("FAIL reverse_busy_ready: got %0d violations expected 0", proto_err); end
    n_checks++; if (!idle_after) begin n_fail++; $display("FAIL reverse_idle_after: got 0 expected 1"); end
  endtask

  task automatic test_duplicates();
    frame_t d = '{8'd5, 8'd255, 8'd0, 8'd5, 8'd128, 8'd0, 8'd255, 8'd1};
    frame_t ea, ed;
    model_sort(d, 1'b0, ea); model_sort(d, 1'b1, ed);
    load_frame(d, 1'b0); unload_frame(0);
    n_checks++; if (timeout) begin n_fail++; $display("FAIL dups_timeout: got %0d words expected %0d", n_got, N); end
    for (int i = 0; i < N; i++) begin
      n_checks++; if (got_a[i] !== ea[i]) begin n_fail++; $display("FAIL dups_asc[%0d]: got %0d expected %0d", i, got_a[i], ea[i]); end
      n_checks++; if (got_d[i] !== ed[i]) begin n_fail++; $display("FAIL dups_desc[%0d]: got %0d expected %0d", i, got_d[i], ed[i]); end
    end
    n_checks++; if (last_d !== 128) begin n_fail++; $display("FAIL dups_last_desc: got mask %0d expected 128", last_d); end
  endtask

  task automatic test_backpressure();
    frame_t d = '{8'd42, 8'd17, 8'd99, 8'd3, 8'd64, 8'd17, 8'd200, 8'd8};
    frame_t ea;
    model_sort(d, 1'b0, ea);
    load_frame(d, 1'b0); unload_frame(1);
    n_checks++; if (n_got !== N) begin n_fail++; $display("FAIL bp_count: got %0d expected %0d", n_got, N); end
    for (int i = 0; i < N; i++) begin
      n_checks++; if (got_a[i] !== ea[i]) begin n_fail++; $display("FAIL bp_asc[%0d]: got %0d expected %0d", i, got_a[i], ea[i]); end
    end
    n_checks++; if (hold_err !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d changes while stalled expected 0", hold_err); end
    n_checks++; if (proto_err !== 0) begin n_fail++; $display("FAIL bp_in_ready: got %0d violations expected 0", proto_err); end
    n_checks++; if (last_a !== 128) begin n_fail++; $display("FAIL bp_last: got mask %0d expected 128", last_a); end
    n_checks++; if (!idle_after) begin n_fail++; $display("FAIL bp_idle_after: got 0 expected 1"); end
  endtask

  task automatic test_reset_mid();
    frame_t junk = '{8'd250, 8'd1, 8'd249, 8'd2, 8'd248, 8'd3, 8'd247, 8'd4};
    frame_t d = '{8'd3, 8'd1, 8'd2, 8'd0, 8'd7, 8'd6, 8'd5, 8'd4};
    frame_t ea, ed;
    model_sort(d, 1'b0, ea); model_sort(d, 1'b1, ed);
    load_frame(junk, 1'b0);
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n_checks++; if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready_a); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy_a); end
    n_checks++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid_a); end
    load_frame(d, 1'b0); unload_frame(0);
    n_checks++; if (timeout) begin n_fail++; $display("FAIL midrst_timeout: got %0d words expected %0d", n_got, N); end
    for (int i = 0; i < N; i++) begin
      n_checks++; if (got_a[i] !== ea[i]) begin n_fail++; $display("FAIL midrst_asc[%0d]: got %0d expected %0d", i, got_a[i], ea[i]); end
      n_checks++; if (got_d[i] !== ed[i]) begin n_fail++; $display("FAIL midrst_desc[%0d]: got %0d expected %0d", i, got_d[i], ed[i]); end
    end
    n_checks++; if (first_valid - hs_cyc !== 9) begin n_fail++; $display("FAIL midrst_latency: got %0d expected 9", first_valid - hs_cyc); end
  endtask

  task automatic test_descend();
    frame_t d = '{8'd10, 8'd40, 8'd20, 8'd30, 8'd0, 8'd50, 8'd70, 8'd60};
    frame_t ed;
    model_sort(d, 1'b1, ed);
    load_frame(d, 1'b0); unload_frame(0);
    n_checks++; if (timeout) begin n_fail++; $display("FAIL desc_timeout: got %0d words expected %0d", n_got, N); end
    for (int i = 0; i < N; i++) begin
      n_checks++; if (got_d[i] !== ed[i]) begin n_fail++; $display("FAIL desc[%0d]: got %0d expected %0d", i, got_d[i], ed[i]); end
    end
    n_checks++; if (last_d !== 128) begin n_fail++; $display("FAIL desc_last: got mask %0d expected 128", last_d); end
  endtask

  task automatic test_presorted_gaps();
    frame_t d = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    frame_t ea, ed;
    model_sort(d, 1'b0, ea); model_sort(d, 1'b1, ed);
    load_frame(d, 1'b1); unload_frame(0);
    n_checks++; if (busy_in_load) begin n_fail++; $display("FAIL gaps_early_sort: got busy during load expected idle"); end
    n_checks++; if (proto_err !== 0) begin n_fail++; $display("FAIL gaps_busy_ready: got %0d violations expected 0", proto_err); end
    n_checks++; if (first_valid - hs_cyc !== 9) begin n_fail++; $display("FAIL gaps_latency: got %0d expected 9", first_valid - hs_cyc); end
    for (int i = 0; i < N; i++) begin
      n_checks++; if (got_a[i] !== ea[i]) begin n_fail++; $display("FAIL gaps_asc[%0d]: got %0d expected %0d", i, got_a[i], ea[i]); end
      n_checks++; if (got_d[i] !== ed[i]) begin n_fail++; $display("FAIL gaps_desc[%0d]: got %0d expected %0d", i, got_d[i], ed[i]); end
    end
  endtask

  task automatic test_random();
    frame_t d, ea, ed;
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < N; i++) d[i] = W'($urandom_range(0, (f < 3) ? 3 : 255));
      model_sort(d, 1'b0, ea); model_sort(d, 1'b1, ed);
      load_frame(d, 1'($urandom_range(0, 1)));
      unload_frame((f % 2 == 0) ? 2 : 1);
      n_checks++; if (timeout) begin n_fail++; $display("FAIL rand%0d_timeout: got %0d words expected %0d", f, n_got, N); end
      for (int i = 0; i < N; i++) begin
        n_checks++; if (got_a[i] !== ea[i]) begin n_fail++; $display("FAIL rand%0d_asc[%0d]: got %0d expected %0d", f, i, got_a[i], ea[i]); end
        n_checks++; if (got_d[i] !== ed[i]) begin n_fail++; $display("FAIL rand%0d_desc[%0d]: got %0d expected %0d", f, i, got_d[i], ed[i]); end
      end
      n_checks++; if (hold_err !== 0) begin n_fail++; $display("FAIL rand%0d_hold: got %0d expected 0", f, hold_err); end
      n_checks++; if (last_a !== 128 || last_d !== 128) begin n_fail++; $display("FAIL rand%0d_last: got %0d/%0d expected 128", f, last_a, last_d); end
      n_checks++; if (!idle_after) begin n_fail++; $display("FAIL rand%0d_idle_after: got 0 expected 1", f); end
    end
  endtask

  initial begin
    test_reset();
    test_reverse();
    test_duplicates();
    test_backpressure();
    test_reset_mid();
    test_descend();
    test_presorted_gaps();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
